mem_bus_access_unit: RTL and testbench
======================================

// Module: mem_bus_access_unit
// PURPOSE
//  Executes the data-memory access decoded by the memory-stage controller (read_size/write_size).
//  Converts {size, addr, wdata} into one word-aligned bus transaction with byte enables.
//  Waits on a req/ack bus and stalls the pipeline until the transaction completes.
//  Returns load data lane-selected and sign/zero-extended for writeback.
//  Sits between the memory-stage controller and the data bus; its load result feeds the MEM/WB register.
// PARAMETERS
//  TIMEOUT   16  bus cycles to wait for bus_ack before flagging bus_fault (>=2)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous active-low reset
//  read_size     in   3   0=no load, 1/2/4 = byte/half/word load
//  write_size    in   3   0=no store, 1/2/4 = byte/half/word store
//  load_unsigned in   1   1 = zero-extend load (lbu/lhu), 0 = sign-extend
//  addr          in   32  byte address
//  wdata         in   32  store data; low bytes significant
//  stall         out  1   1 = hold MEM stage and everything upstream
//  rdata         out  32  extended load result; valid when ld_valid=1
//  ld_valid      out  1   one-cycle pulse: rdata valid, access retired
//  align_fault   out  1   combinational: misaligned or illegal size request
//  bus_fault     out  1   one-cycle pulse on timeout
//  bus_req       out  1   request; held until ack
//  bus_we        out  1   1 = write
//  bus_addr      out  32  {addr[31:2],2'b00}
//  bus_be        out  4   byte enables
//  bus_wdata     out  32  store data replicated to the active lanes
//  bus_ack       in   1   completes request in the same cycle as bus_req=1
//  bus_rdata     in   32  read word; sampled when bus_ack=1
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; counter=0; all registered outputs 0.
//    bus_req=0, ld_valid=0, bus_fault=0, rdata=0.
//  - Request valid: exactly one of read_size/write_size is nonzero, and that value is in {1,2,4}.
//  - align_fault=1 if any of the following holds:
//    - both sizes are nonzero;
//    - the size is 3, 5, 6 or 7;
//    - size=2 and addr[0]=1;
//    - size=4 and addr[1:0]!=0.
//    A faulting request never leaves IDLE and issues no bus cycle. stall=0.
//  - FSM IDLE->BUSY->DONE->IDLE.
//    - IDLE: on a valid request, latch addr, be, wdata, we and load_unsigned; go to BUSY.
//      stall=1 combinationally in that same cycle.
//    - BUSY: bus_req=1 and stall=1. The latched fields drive the bus unchanged.
//      - bus_ack=1: capture bus_rdata and go to DONE.
//      - Counter reaches TIMEOUT-1 with no ack: pulse bus_fault and go to IDLE. ld_valid stays 0.
//    - DONE: stall=0 and ld_valid=1. rdata holds the extended value. Return to IDLE.
//      The upstream stage advances this cycle, so a new request in the next cycle is a new access.
//  - Byte enables: size1 -> 4'b0001<<addr[1:0]; size2 -> 4'b0011<<addr[1:0]; size4 -> 4'hF.
//  - bus_wdata: size1 -> {4{wdata[7:0]}}; size2 -> {2{wdata[15:0]}}; size4 -> wdata.
//  - Load extension: select lane bus_rdata[8*addr[1:0]+:8] (byte) or [16*addr[1]+:16] (half).
//    Sign-extend when load_unsigned=0, else zero-extend. Stores leave rdata unchanged.
//  - Minimum latency: request cycle, then ack in the first BUSY cycle, then DONE. Total 2 stall cycles.
//  - Inputs are ignored outside IDLE because upstream is stalled. Latched copies are authoritative.
//  - bus_ack while bus_req=0 is ignored.
//  - Reset mid-BUSY drops bus_req immediately. A late bus_ack after reset is ignored.
// STRUCTURE
//  - Shared package mem_pkg:
//    - size constants SZ_NONE=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4;
//    - state enum {ST_IDLE, ST_BUSY, ST_DONE};
//    - function be_of(size, addr_lo).
//  - Sub-module load_extender: combinational. Inputs word, addr_lo[1:0], size, unsigned; output ext[31:0].
// TESTING
//  - lw addr=0x100 (read_size=4), ack after 3 BUSY cycles, bus_rdata=0xDEADBEEF.
//    Required: bus_be=F, 4 stall cycles, then ld_valid with rdata=0xDEADBEEF.
//  - lb addr=0x103, bus_rdata=0x80123456, load_unsigned=0 -> be=4'b1000, rdata=0xFFFFFF80.
//    Same with lbu -> rdata=0x00000080.
//  - sh addr=0x202, wdata=0x0000ABCD, immediate ack.
//    Required: bus_we=1, be=4'b1100, bus_wdata=0xABCDABCD, ld_valid pulse, rdata unchanged.
//  - lw addr=0x101 -> align_fault=1, bus_req never asserts, stall=0.
//    read_size=1 with write_size=1 -> align_fault=1.
//  - No ack for TIMEOUT=16 cycles -> bus_fault pulses once, state returns to IDLE, stall drops.
//  - rst_n low in the 2nd BUSY cycle -> bus_req=0 asynchronously; ack asserted afterwards yields no ld_valid.

Source files
------------

// File: rtl/mem_bus_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access sizes,
// FSM states and the byte-lane helpers used when a request is latched.
package mem_pkg;

    localparam logic [2:0] SZ_NONE = 3'd0;
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] be_of(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: be_of = 4'b0001 << addr_lo;
            SZ_HALF: be_of = 4'b0011 << addr_lo;
            SZ_WORD: be_of = 4'hF;
            default: be_of = 4'h0;
        endcase
    endfunction

    // Store data replicated so every enabled lane sees the right bytes.
    function automatic logic [31:0] wdata_of(input logic [2:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: wdata_of = {4{wdata[7:0]}};
            SZ_HALF: wdata_of = {2{wdata[15:0]}};
            default: wdata_of = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_access_unit_if.sv
// Word-wide data bus with a req/ack handshake. The access unit is the
// master; the memory (or testbench) is the slave.
interface mem_bus_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_bus_access_unit_load_extender.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends
// it to 32 bits. Word loads pass through untouched.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select, then extension by size; unknown sizes fall back to the word.
    always_comb begin
        w_byte = i_word[8*i_addr_lo +: 8];
        w_half = i_word[16*i_addr_lo[1] +: 16];
        case (i_size)
            SZ_BYTE: o_ext = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_ext = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_ext = i_word;
        endcase
    end

endmodule

// File: rtl/mem_bus_access_unit.sv
// Memory-stage bus access unit: turns {size, addr, wdata} into one aligned
// bus transaction, stalls the pipeline while it is outstanding, and returns
// the extended load result with a one-cycle ld_valid.
module mem_bus_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  read_size,
    input  logic [2:0]  write_size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        ld_valid,
    output logic        align_fault,
    output logic        bus_fault,
    mem_bus_access_unit_if.master bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic         r_bus_req;
    logic         r_ld_valid;
    logic         r_bus_fault;
    logic [31:0]  r_rdata;
    logic [31:0]  r_addr;
    logic [3:0]   r_be;
    logic [31:0]  r_wdata;
    logic         r_we;
    logic [2:0]   r_size;
    logic         r_unsigned;

    logic [2:0]   w_size;
    logic         w_has_req;
    logic         w_start;
    logic [31:0]  w_ext;

    // Request decode: only one size may be active, and it must fit its alignment.
    always_comb begin
        w_has_req   = (read_size != SZ_NONE) || (write_size != SZ_NONE);
        w_size      = (read_size != SZ_NONE) ? read_size : write_size;
        align_fault = w_has_req &&
                      (((read_size != SZ_NONE) && (write_size != SZ_NONE)) ||
                       !((w_size == SZ_BYTE) || (w_size == SZ_HALF) || (w_size == SZ_WORD)) ||
                       ((w_size == SZ_HALF) && addr[0]) ||
                       ((w_size == SZ_WORD) && (addr[1:0] != 2'b00)));
        w_start     = (r_state == ST_IDLE) && w_has_req && !align_fault;
        stall       = w_start || (r_state == ST_BUSY);
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = {r_addr[31:2], 2'b00};
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;

    assign rdata     = r_rdata;
    assign ld_valid  = r_ld_valid;
    assign bus_fault = r_bus_fault;

    load_extender u_ext (
        .i_word     (bus.bus_rdata),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_ext      (w_ext)
    );

    // Access FSM: latch the request, hold the bus until ack or timeout, retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_ld_valid  <= 1'b0;
            r_bus_fault <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_size      <= SZ_NONE;
            r_unsigned  <= 1'b0;
        end else begin
            r_ld_valid  <= 1'b0;
            r_bus_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr     <= addr;
                        r_be       <= be_of(w_size, addr[1:0]);
                        r_wdata    <= wdata_of(w_size, wdata);
                        r_we       <= (write_size != SZ_NONE);
                        r_size     <= w_size;
                        r_unsigned <= load_unsigned;
                        r_cnt      <= '0;
                        r_bus_req  <= 1'b1;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ack) begin
                        // Stores keep the previous load result on rdata.
                        if (!r_we) r_rdata <= w_ext;
                        r_bus_req  <= 1'b0;
                        r_ld_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_bus_req   <= 1'b0;
                        r_bus_fault <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_access_unit.sv
// Bench for mem_bus_access_unit: directed cases plus randomized accesses,
// all checked against a transaction-level model of lanes, enables and latency.
module tb_mem_bus_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  read_size = '0;
    logic [2:0]  write_size = '0;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        ld_valid;
    logic        align_fault;
    logic        bus_fault;

    mem_bus_access_unit_if u_bus ();

    mem_bus_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_size     (read_size),
        .write_size    (write_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .stall         (stall),
        .rdata         (rdata),
        .ld_valid      (ld_valid),
        .align_fault   (align_fault),
        .bus_fault     (bus_fault),
        .bus           (u_bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_fault(input logic [2:0] rs, input logic [2:0] ws, input logic [31:0] a);
        int sz;
        if (rs == 0 && ws == 0) return 1'b0;
        if (rs != 0 && ws != 0) return 1'b1;
        sz = int'(rs | ws);
        if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
        logic [3:0] be = '0;
        int lo = int'(a[1:0]);
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + sz) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input int sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ext(input int sz, input logic [31:0] a,
                                            input bit uns, input logic [31:0] word);
        logic [31:0] v, mask;
        if (sz == 4) return word;
        v    = word >> (8 * int'(a[1:0]));
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if (!uns && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One access from request through retirement; dly = BUSY cycles before ack.
    task automatic access(input logic [2:0] rs, input logic [2:0] ws, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int dly);
        bit flt, act, acked;
        int sz, stalls, k;
        flt = exp_fault(rs, ws, a);
        act = (rs != 0 || ws != 0) && !flt;
        sz  = int'(rs | ws);
        cyc();
        read_size = rs; write_size = ws; load_unsigned = uns; addr = a; wdata = wd;
        u_bus.bus_ack = 1'($urandom_range(0, 1));
        u_bus.bus_rdata = $urandom;
        @(negedge clk);
        chk("align_fault", 32'(align_fault), 32'(flt));
        chk("req_stall", 32'(stall), 32'(act));
        chk("req_idle_busreq", 32'(u_bus.bus_req), 32'd0);
        if (!act) begin
            cyc();
            read_size = '0; write_size = '0; u_bus.bus_ack = 1'b0;
            @(negedge clk);
            chk("noacc_busreq", 32'(u_bus.bus_req), 32'd0);
            chk("noacc_ldvalid", 32'(ld_valid), 32'd0);
            return;
        end
        stalls = 1; k = 0; acked = 0;
        forever begin
            cyc();
            // Inputs change freely while busy; the latched copy must drive the bus.
            read_size = 3'($urandom); write_size = 3'($urandom);
            load_unsigned = 1'($urandom); addr = $urandom; wdata = $urandom;
            u_bus.bus_ack   = (k == dly);
            u_bus.bus_rdata = (k == dly) ? word : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(u_bus.bus_req), 32'd1);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_addr", u_bus.bus_addr, a & ~32'd3);
            chk("busy_be", 32'(u_bus.bus_be), 32'(exp_be(sz, a)));
            chk("busy_we", 32'(u_bus.bus_we), 32'(ws != 0));
            if (ws != 0) chk("busy_wdata", u_bus.bus_wdata, exp_wd(sz, wd));
            stalls++;
            if (k == dly) begin acked = 1; break; end
            if (k == TIMEOUT - 1) break;
            k++;
        end
        cyc();
        read_size = '0; write_size = '0;
        u_bus.bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (acked) begin
            if (rs != 0) m_rdata = exp_ext(sz, a, uns, word);
            chk("done_ldvalid", 32'(ld_valid), 32'd1);
            chk("done_fault", 32'(bus_fault), 32'd0);
            chk("stall_cycles", 32'(stalls), 32'(dly + 2));
        end else begin
            chk("to_fault", 32'(bus_fault), 32'd1);
            chk("to_ldvalid", 32'(ld_valid), 32'd0);
            chk("to_cycles", 32'(stalls - 1), 32'(TIMEOUT));
        end
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_busreq", 32'(u_bus.bus_req), 32'd0);
        chk("done_rdata", rdata, m_rdata);
        cyc();
        u_bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("after_ldvalid", 32'(ld_valid), 32'd0);
        chk("after_fault", 32'(bus_fault), 32'd0);
    endtask

    initial begin
        u_bus.bus_ack = 1'b0;
        u_bus.bus_rdata = '0;
        #12;
        chk("rst_busreq", 32'(u_bus.bus_req), 32'd0);
        chk("rst_ldvalid", 32'(ld_valid), 32'd0);
        chk("rst_fault", 32'(bus_fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        #10 rst_n = 1'b1;

        // lw with ack in the third BUSY cycle
        access(3'd0 + 3'd4, 3'd0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        // lb / lbu from the top lane
        access(3'd1, 3'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        access(3'd1, 3'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0);
        chk("lbu_rdata", rdata, 32'h00000080);
        // sh to the upper half; rdata must keep the lbu result
        access(3'd0, 3'd2, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0);
        chk("sh_rdata_kept", rdata, 32'h00000080);
        // faulting requests
        access(3'd4, 3'd0, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        access(3'd1, 3'd1, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        // timeout
        access(3'd4, 3'd0, 1'b0, 32'h300, 32'h0, 32'h0, 100);

        // reset in the second BUSY cycle
        cyc();
        read_size = 3'd4; addr = 32'h100;
        @(negedge clk);
        chk("rstb_stall", 32'(stall), 32'd1);
        cyc();
        read_size = '0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        m_rdata = '0;
        chk("rstb_busreq", 32'(u_bus.bus_req), 32'd0);
        chk("rstb_stall0", 32'(stall), 32'd0);
        u_bus.bus_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            u_bus.bus_ack = 1'b1;
            @(negedge clk);
            chk("rstb_ldvalid", 32'(ld_valid), 32'd0);
            chk("rstb_busreq_late", 32'(u_bus.bus_req), 32'd0);
        end
        u_bus.bus_ack = 1'b0;

        // randomized accesses
        for (int t = 0; t < 80; t++) begin
            logic [2:0]  rs, ws, sz;
            logic [31:0] a;
            int          r, dly;
            r  = $urandom_range(0, 9);
            a  = $urandom;
            rs = '0; ws = '0;
            if (r == 0) begin
                rs = 3'($urandom_range(1, 7)); ws = 3'($urandom_range(1, 7));
            end else if (r == 1) begin
                sz = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(5, 7));
                if ($urandom_range(0, 1) == 0) rs = sz; else ws = sz;
            end else if (r >= 3) begin
                case ($urandom_range(0, 2))
                    0: sz = 3'd1;
                    1: sz = 3'd2;
                    default: sz = 3'd4;
                endcase
                if ($urandom_range(0, 9) < 7) a = a & ~(32'(sz) - 32'd1);
                if ($urandom_range(0, 1) == 0) rs = sz; else ws = sz;
            end
            dly = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 4);
            access(rs, ws, 1'($urandom), a, $urandom, $urandom, dly);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so a stuck run still reports.
    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
